// File: rtl/median_5x5_frame_ctrl.sv
// Frame sequencer for the 5x5 median pipeline: walks the raster and gates window-valid strobes.
// It also counts calculator results and reports frame completion, drain timeout and protocol errors.
module median_5x5_frame_ctrl #(
  parameter int MAX_W    = 1024,
  parameter int MAX_H    = 1024,
  parameter int DIM_BITS = 11,
  parameter int CALC_LAT = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DIM_BITS-1:0] width_i,
  input  logic [DIM_BITS-1:0] height_i,
  input  logic                pix_valid_i,
  output logic                pix_ready_o,
  output logic                shift_en_o,
  output logic                win_valid_o,
  input  logic                calc_done_i,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                cfg_err_o,
  output logic [1:0]          err_o
);
  localparam int EW = 2 * DIM_BITS;
  localparam int CW = $clog2(CALC_LAT + 4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]          state;
  logic [DIM_BITS-1:0] w, h, col, row;
  logic [EW-1:0]       out_cnt, exp_cnt;
  logic [CW-1:0]       cyc_cnt;
  logic                win_valid, frame_done, cfg_err;
  logic [1:0]          err;
  logic                cfg_bad, counting, at_exp, last_pix;

  always_comb begin
    cfg_bad     = (width_i < DIM_BITS'(5)) || (width_i > DIM_BITS'(MAX_W)) ||
                  (height_i < DIM_BITS'(5)) || (height_i > DIM_BITS'(MAX_H));
    counting    = (state == S_RUN) || (state == S_DRAIN);
    at_exp      = (out_cnt == exp_cnt);
    // abort blocks acceptance in the same cycle, including a final pixel
    pix_ready_o = (state == S_RUN) && !abort_i;
    shift_en_o  = pix_valid_i && pix_ready_o;
    last_pix    = shift_en_o && (col == w - DIM_BITS'(1)) && (row == h - DIM_BITS'(1));
    out_last_o  = calc_done_i && counting && (out_cnt == exp_cnt - EW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      w          <= '0;
      h          <= '0;
      col        <= '0;
      row        <= '0;
      out_cnt    <= '0;
      exp_cnt    <= '0;
      cyc_cnt    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      err        <= 2'b00;
    end else begin
      win_valid  <= shift_en_o && (row >= DIM_BITS'(4)) && (col >= DIM_BITS'(4));
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (calc_done_i && ((state == S_IDLE) || (counting && at_exp)))
        err[1] <= 1'b1;
      if (calc_done_i && counting && !at_exp)
        out_cnt <= out_cnt + EW'(1);
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              w       <= width_i;
              h       <= height_i;
              col     <= '0;
              row     <= '0;
              out_cnt <= '0;
              err     <= 2'b00;
              exp_cnt <= EW'(width_i - DIM_BITS'(4)) * EW'(height_i - DIM_BITS'(4));
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort_i) begin
            state   <= S_FLUSH;
            cyc_cnt <= '0;
          end else if (shift_en_o) begin
            if (col == w - DIM_BITS'(1)) begin
              col <= '0;
              row <= row + DIM_BITS'(1);
            end else begin
              col <= col + DIM_BITS'(1);
            end
            if (last_pix) begin
              state   <= S_DRAIN;
              cyc_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (abort_i) begin
            state   <= S_FLUSH;
            cyc_cnt <= '0;
          end else if (out_last_o) begin
            state      <= S_IDLE;
            frame_done <= 1'b1;
          end else if (cyc_cnt == CW'(CALC_LAT + 2)) begin
            err[0]  <= 1'b1;
            state   <= S_FLUSH;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: begin
          // let in-flight calculator results fall out unobserved
          if (cyc_cnt == CW'(CALC_LAT + 1)) state <= S_IDLE;
          else cyc_cnt <= cyc_cnt + CW'(1);
        end
      endcase
    end
  end

  assign win_valid_o  = win_valid;
  assign busy_o       = (state != S_IDLE);
  assign frame_done_o = frame_done;
  assign cfg_err_o    = cfg_err;
  assign err_o        = err;
endmodule

// File: tb/tb_median_5x5_frame_ctrl.sv
// Directed bench for median_5x5_frame_ctrl with a fixed-latency calculator model
// and a raster tracker that predicts every window strobe.
module tb_median_5x5_frame_ctrl;
  localparam int DB  = 11;
  localparam int LAT = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0, pix_valid_i = 1'b0;
  logic [DB-1:0] width_i = '0, height_i = '0;
  logic          pix_ready_o, shift_en_o, win_valid_o, out_last_o;
  logic          busy_o, frame_done_o, cfg_err_o;
  logic [1:0]    err_o;
  logic          calc_done_i;

  median_5x5_frame_ctrl #(.MAX_W(1024), .MAX_H(1024), .DIM_BITS(DB), .CALC_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .width_i(width_i), .height_i(height_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .shift_en_o(shift_en_o), .win_valid_o(win_valid_o),
    .calc_done_i(calc_done_i), .out_last_o(out_last_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .cfg_err_o(cfg_err_o), .err_o(err_o));

  always #5 clk = ~clk;

  // calculator model: done exactly LAT cycles after win_valid, optionally dropping window #supp
  logic [LAT-1:0] pipe = '0;
  int             mwin = 0;
  int             supp = 0;
  logic           force_done = 1'b0;
  logic           clr = 1'b0;
  always @(posedge clk) begin
    pipe <= {pipe[LAT-2:0], win_valid_o && !(supp != 0 && mwin + 1 == supp)};
    if (clr) mwin <= 0;
    else if (win_valid_o) mwin <= mwin + 1;
  end
  assign calc_done_i = pipe[LAT-1] | force_done;

  // monitor
  int cur_w = 0, cur_h = 0, cyc = 0;
  int px, py, win_cnt, done_cnt, last_idx, fd_cnt, cfg_cnt, pix_cnt, win_err, seq_err;
  int last_cyc, err0_cyc;
  bit exp_win, prev_last, busy_seen, err0_seen;
  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      px = 0; py = 0; exp_win = 0; prev_last = 0; win_cnt = 0; done_cnt = 0; last_idx = 0;
      fd_cnt = 0; cfg_cnt = 0; pix_cnt = 0; win_err = 0; seq_err = 0; busy_seen = 0;
      last_cyc = 0; err0_cyc = 0; err0_seen = 0;
    end else begin
      if (win_valid_o !== exp_win) win_err++;
      if (win_valid_o) win_cnt++;
      if (calc_done_i) begin
        done_cnt++;
        if (out_last_o) last_idx = done_cnt;
      end
      if (frame_done_o) begin
        fd_cnt++;
        if (!prev_last || busy_o) seq_err++;
      end
      prev_last = out_last_o;
      if (cfg_err_o) cfg_cnt++;
      if (busy_o) busy_seen = 1;
      if (err_o[0] && !err0_seen) begin err0_seen = 1; err0_cyc = cyc; end
      exp_win = shift_en_o && px >= 4 && py >= 4;
      if (shift_en_o) begin
        pix_cnt++;
        if (px == cur_w - 1 && py == cur_h - 1) last_cyc = cyc;
        if (px == cur_w - 1) begin px = 0; py++; end
        else px++;
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon(input int w, input int h, input int sp);
    cur_w = w; cur_h = h; supp = sp;
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input bit tog, input int sp);
    int n;
    clear_mon(w, h, sp);
    width_i = DB'(w); height_i = DB'(h);
    pix_valid_i = 1'b1; start_i = 1'b1; tick(); start_i = 1'b0;
    n = 0;
    while (busy_o && n < 5000) begin
      n++; tick();
      if (tog) pix_valid_i = ~pix_valid_i;
    end
    if (n >= 5000) check("frame_timeout", 1, 0);
    pix_valid_i = 1'b0;
    repeat (20) tick();
  endtask

  typedef struct { int w; int h; bit tog; int win; int fd; int cfg; } vec_t;
  vec_t vecs[7];

  initial begin
    int n, rdy_bad;
    vecs[0] = '{8,    6,  1'b0,  8, 1, 0};
    vecs[1] = '{8,    6,  1'b1,  8, 1, 0};
    vecs[2] = '{4,    10, 1'b0,  0, 0, 1};
    vecs[3] = '{1025, 5,  1'b0,  0, 0, 1};
    vecs[4] = '{10,   4,  1'b0,  0, 0, 1};
    vecs[5] = '{5,    5,  1'b1,  1, 1, 0};
    vecs[6] = '{7,    9,  1'b0, 15, 1, 0};

    repeat (3) @(negedge clk);
    check("rst_pix_ready", pix_ready_o, 0);
    check("rst_win_valid", win_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    check("rst_err", err_o, 0);
    check("rst_out_last", out_last_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_frame(vecs[i].w, vecs[i].h, vecs[i].tog, 0);
      check($sformatf("v%0d_windows", i), win_cnt, vecs[i].win);
      check($sformatf("v%0d_dones", i), done_cnt, vecs[i].win);
      check($sformatf("v%0d_last_idx", i), last_idx, vecs[i].win);
      check($sformatf("v%0d_frame_done", i), fd_cnt, vecs[i].fd);
      check($sformatf("v%0d_cfg_err", i), cfg_cnt, vecs[i].cfg);
      check($sformatf("v%0d_busy_seen", i), busy_seen, vecs[i].cfg == 0);
      check($sformatf("v%0d_err", i), err_o, 0);
      check($sformatf("v%0d_win_timing", i), win_err, 0);
      check($sformatf("v%0d_done_seq", i), seq_err, 0);
    end

    // abort after 20 pixels of a 16x16 frame, with a pixel offered in the abort cycle
    clear_mon(16, 16, 0);
    width_i = 16; height_i = 16; pix_valid_i = 1'b1; start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (20) tick();
    abort_i = 1'b1; #1;
    check("abort_ready_low", pix_ready_o, 0);
    check("abort_no_shift", shift_en_o, 0);
    tick(); abort_i = 1'b0; pix_valid_i = 1'b0;
    width_i = 5; height_i = 5;
    n = 0; rdy_bad = 0;
    while (busy_o && n < 40) begin
      n++;
      force_done = (n == 3 || n == 4);
      start_i = (n == 5);
      if (pix_ready_o) rdy_bad++;
      tick();
    end
    force_done = 1'b0; start_i = 1'b0;
    repeat (3) tick();
    check("flush_len", n, 14);
    check("flush_ready", rdy_bad, 0);
    check("abort_pixels", pix_cnt, 20);
    check("abort_err", err_o, 0);
    check("abort_no_done", fd_cnt, 0);
    check("flush_start_ignored", cfg_cnt, 0);
    run_frame(5, 5, 1'b0, 0);
    check("post_abort_windows", win_cnt, 1);
    check("post_abort_done", fd_cnt, 1);

    // 6x6 frame with the final result suppressed
    run_frame(6, 6, 1'b0, 4);
    check("tmo_dones", done_cnt, 3);
    check("tmo_err", err_o, 1);
    check("tmo_no_done", fd_cnt, 0);
    check("tmo_delay", err0_cyc - last_cyc, 16);
    supp = 0;
    run_frame(5, 5, 1'b0, 0);
    check("tmo_err_cleared", err_o, 0);
    check("tmo_next_done", fd_cnt, 1);

    // done while idle
    force_done = 1'b1; tick(); force_done = 1'b0;
    check("idle_done_err", err_o, 2);
    repeat (5) tick();
    check("idle_done_held", err_o, 2);
    clear_mon(5, 5, 0);
    width_i = 5; height_i = 5; pix_valid_i = 1'b0; start_i = 1'b1; tick(); start_i = 1'b0;
    check("start_clears_err", err_o, 0);
    check("first_ready", pix_ready_o, 1);

    // reset mid-frame
    pix_valid_i = 1'b1;
    repeat (8) tick();
    rst_n = 1'b0; #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_ready", pix_ready_o, 0);
    pix_valid_i = 1'b0;
    tick(); rst_n = 1'b1;
    repeat (20) tick();
    check("midrst_no_done", fd_cnt, 0);
    check("midrst_err", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
